ram_sp_clr: RTL and testbench
=============================

# ram_sp_clr

Parametrised single-port synchronous RAM with a registered read port, read-valid flag, and a hardware clear engine that zero-fills the whole array after reset or on request. It is the general-purpose scratch/buffer memory for datapath blocks. It replaces fixed 8-bit/16-entry storage with configurable width and depth, and guarantees known contents after reset.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select; qualifies every access
- wr_en  in  1  1 = write, 0 = read (when cs=1)
- out_en  in  1  output drive enable for data_out
- clr  in  1  single-cycle request to zero-fill the array
- address_in  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  registered read data
- rd_valid  out  1  read data captured last cycle
- busy  out  1  clear engine active; accesses ignored

## Operation
- FSM states: CLEAR, IDLE.
- Reset puts the FSM in CLEAR with the clear pointer at 0.
- CLEAR:
  - writes 0 to memory[ptr] every cycle and increments ptr.
  - after writing DEPTH-1, moves to IDLE on the next edge and resets ptr to 0.
  - busy=1 throughout.
- IDLE:
  - clr=1 moves to CLEAR (ptr=0).
  - cs&&wr_en writes data_in to memory[address_in].
  - cs&&!wr_en loads memory[address_in] into the read register and sets rd_valid for one cycle.
  - A cycle with no read clears rd_valid.
- The read register holds its last value until the next read. It is not cleared by the clear engine.
- Accesses while busy=1 are dropped: no write, read register unchanged, rd_valid=0.
- clr while busy=1 is ignored; the sweep does not restart.
- clr together with an access in IDLE: clear wins and the access is dropped.
- Address wrap: ADDR_WIDTH bits cover DEPTH exactly, so no out-of-range address exists.
- The ptr counter is ADDR_WIDTH bits. Terminal detection is ptr == DEPTH-1, with no extra bit.

## Timing
- Reset values: busy=1, rd_valid=0, read register=0, state=CLEAR, ptr=0.
- With out_en=1 during reset, data_out=0.
- Clear duration is exactly DEPTH cycles from reset release or from the clr edge. busy falls on the edge after the last zero write.
- Write latency: data is visible to a read issued on the following cycle.
- Read latency is 1 cycle. Address sampled at edge N gives data_out and rd_valid=1 after edge N.
- Back-to-back reads give one word per cycle, with rd_valid held high.
- Read and write use the same port, so there is no read-during-write case.
- rst_n asserted mid-clear or mid-read aborts immediately: outputs take reset values, the sweep restarts from 0 after release, and partially cleared contents are swept again.

## Configuration
- RAM_TRISTATE_EN defined:
  - data_out = read register when out_en=1, otherwise all-Z.
  - For use on a shared bus.
- Undefined:
  - data_out = read register when out_en=1, otherwise all-0.
  - No tri-state logic, for on-chip muxed use.

## Structure
- Package ram_pkg holds:
  - the FSM state enum (CLEAR, IDLE)
  - a default DATA_WIDTH/ADDR_WIDTH pair
  - a DEPTH helper function
- One sub-module, ram_clear_fsm, holds the state, ptr, busy and the clear-write strobe/address. The top-level muxes the write port between the clear engine and the user.

## Test plan
- Reset release with DATA_WIDTH=8, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles, then 0; a read of every address returns 0x00.
- Write 0xA5 at address 3, read address 3 next cycle -> data_out=0xA5, rd_valid=1 one cycle after the read edge, then 0.
- Write 0x11..0x1F to addresses 1..15, pulse clr, read back all -> every word 0x00 after busy falls; reads issued during busy give rd_valid=0.
- Write to address 5 during busy -> ignored; address 5 reads 0x00 after the clear.
- rst_n pulsed at clear cycle 7 -> busy stays 1 for 16 full cycles after release.
- out_en=0 -> data_out all-Z with RAM_TRISTATE_EN, all-0 without; out_en=1 shows the last read value (0xA5) in both builds.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and defaults for the single-port RAM with hardware clear engine.
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: sweeps zeros across the whole array after reset or on a clr request.
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(depth(ADDR_WIDTH) - 1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // A clr arriving mid-sweep is deliberately ignored; the sweep never restarts.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLEAR: begin
            if (ptr_q == PTR_LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   assign busy     = (state_q == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM, registered read, zero-filled by a clear engine after reset/clr.
// Build option RAM_TRISTATE_EN: data_out floats when out_en=0 instead of driving 0.
module ram_sp_clr
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  wr_en,
   input  logic                  out_en,
   input  logic                  clr,
   input  logic [ADDR_WIDTH-1:0] address_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  busy
);

   localparam int DEPTH = depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  acc, rd_en, we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   ram_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A clr in IDLE takes priority over a same-cycle user access.
   always_comb begin
      acc        = cs && !busy && !clr;
      rd_en      = acc && !wr_en;
      we         = clr_we || (acc && wr_en);
      waddr      = clr_we ? clr_addr : address_in;
      wdata      = clr_we ? '0 : data_in;
      rd_data_d  = rd_en ? mem[address_in] : rd_data_q;
      rd_valid_d = rd_en;
   end

   // Array itself carries no reset; the clear engine provides known contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_valid = rd_valid_q;

`ifdef RAM_TRISTATE_EN
   assign data_out = out_en ? rd_data_q : {DATA_WIDTH{1'bz}};
`else
   assign data_out = out_en ? rd_data_q : '0;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// Self-checking bench for ram_sp_clr: vector table plus clear/reset corner sequences.
module tb_ram_sp_clr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs, wr_en, out_en, clr;
   logic [3:0] address_in;
   logic [7:0] data_in;
   wire  [7:0] data_out;
   wire        rd_valid;
   wire        busy;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   ram_sp_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .out_en(out_en),
      .clr(clr), .address_in(address_in), .data_in(data_in),
      .data_out(data_out), .rd_valid(rd_valid), .busy(busy)
   );

   typedef struct {
      logic       cs;
      logic       we;
      logic       clr;
      logic [3:0] addr;
      logic [7:0] din;
      logic       exp_v;
      logic [7:0] exp_d;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; called #1 after a rising edge, returns #1 after the next.
   task automatic cyc(input logic c, input logic w, input logic cl, input logic [3:0] a,
                      input logic [7:0] d, input logic ev, input logic [7:0] ed);
      logic [7:0] e;
      cs = c; wr_en = w; clr = cl; address_in = a; data_in = d;
      if (ev) exp_q.push_back(ed);
      @(posedge clk); #1;
      chk("rd_valid", rd_valid, ev);
      if (ev) begin
         if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("data_out", data_out, e);
         end
      end
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      while (busy && n < 100) begin
         cyc(0, 0, 0, 4'd0, 8'd0, 0, 8'd0);
         n++;
      end
      chk(name, n, 16);
   endtask

   initial begin
      int n;
      rst_n = 0; cs = 0; wr_en = 0; out_en = 1; clr = 0; address_in = 0; data_in = 0;

      tbl[0]  = '{1, 1, 0, 4'd3,  8'hA5, 0, 8'h00};
      tbl[1]  = '{1, 0, 0, 4'd3,  8'h00, 1, 8'hA5};
      tbl[2]  = '{0, 0, 0, 4'd0,  8'h00, 0, 8'h00};
      tbl[3]  = '{1, 1, 0, 4'd0,  8'h3C, 0, 8'h00};
      tbl[4]  = '{1, 1, 0, 4'd15, 8'h7E, 0, 8'h00};
      tbl[5]  = '{1, 0, 0, 4'd15, 8'h00, 1, 8'h7E};
      tbl[6]  = '{1, 0, 0, 4'd0,  8'h00, 1, 8'h3C};
      tbl[7]  = '{0, 0, 0, 4'd3,  8'h00, 0, 8'h00};
      tbl[8]  = '{1, 1, 0, 4'd0,  8'h99, 0, 8'h00};
      tbl[9]  = '{1, 0, 0, 4'd0,  8'h00, 1, 8'h99};
      tbl[10] = '{1, 0, 0, 4'd7,  8'h00, 1, 8'h00};
      tbl[11] = '{1, 0, 0, 4'd3,  8'h00, 1, 8'hA5};

      #3;
      chk("reset_busy", busy, 1);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_data_out", data_out, 0);

      #19 rst_n = 1;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("init_clear_cycles", n, 16);

      for (int a = 0; a < 16; a++) cyc(1, 0, 0, 4'(a), 8'd0, 1, 8'h00);
      cyc(0, 0, 0, 4'd0, 8'd0, 0, 8'd0);

      for (int i = 0; i < 12; i++)
         cyc(tbl[i].cs, tbl[i].we, tbl[i].clr, tbl[i].addr, tbl[i].din, tbl[i].exp_v, tbl[i].exp_d);
      cyc(0, 0, 0, 4'd0, 8'd0, 0, 8'd0);

      out_en = 0; #1;
`ifdef RAM_TRISTATE_EN
      chk("out_en0_z", (data_out === 8'bzzzzzzzz), 1);
`else
      chk("out_en0_zero", data_out, 8'h00);
`endif
      out_en = 1; #1;
      chk("out_en1_hold", data_out, 8'hA5);

      for (int a = 1; a < 16; a++) cyc(1, 1, 0, 4'(a), 8'(8'h10 + a), 0, 8'd0);
      cyc(1, 0, 0, 4'd2, 8'd0, 1, 8'h12);
      cyc(1, 0, 1, 4'd2, 8'd0, 0, 8'd0);
      n = 0;
      while (busy && n < 100) begin
         if (n == 0)      cyc(1, 1, 0, 4'd5, 8'hFF, 0, 8'd0);
         else if (n == 3) cyc(1, 0, 1, 4'd9, 8'd0, 0, 8'd0);
         else             cyc(1, 0, 0, 4'(n), 8'd0, 0, 8'd0);
         n++;
      end
      chk("clr_cycles", n, 16);
      chk("rdreg_kept_through_clear", data_out, 8'h12);
      for (int a = 0; a < 16; a++) cyc(1, 0, 0, 4'(a), 8'd0, 1, 8'h00);

      cyc(1, 1, 0, 4'd4, 8'h44, 0, 8'd0);
      cyc(1, 0, 0, 4'd4, 8'd0, 1, 8'h44);
      cyc(0, 0, 1, 4'd0, 8'd0, 0, 8'd0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 4'd0, 8'd0, 0, 8'd0);
      #2 rst_n = 0; #1;
      chk("midclr_rst_busy", busy, 1);
      chk("midclr_rst_rd_valid", rd_valid, 0);
      chk("midclr_rst_data_out", data_out, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      n = 1;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_restart_cycles", n, 16);
      cyc(1, 0, 0, 4'd4, 8'd0, 1, 8'h00);
      cyc(0, 0, 0, 4'd0, 8'd0, 0, 8'd0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
